// File: rtl/hms_pkg.sv
// -----------------------------------------------------------------------------
// hms_pkg
// Shared definitions for the hms_timekeeper time-of-day stage:
//   - field width and range limits for hour/minute/second
//   - controller state encoding (IDLE, RUN, LOAD)
//   - hms_t, the packed hour/minute/second record
// -----------------------------------------------------------------------------
package hms_pkg;

    localparam int TIME_W = 6;

    localparam logic [TIME_W-1:0] HOUR_MAX = 6'd23;
    localparam logic [TIME_W-1:0] MIN_MAX  = 6'd59;
    localparam logic [TIME_W-1:0] SEC_MAX  = 6'd59;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    typedef struct packed {
        logic [TIME_W-1:0] hour;
        logic [TIME_W-1:0] min;
        logic [TIME_W-1:0] sec;
    } hms_t;

endpackage

// File: rtl/hms_tick_gen.sv
// -----------------------------------------------------------------------------
// hms_tick_gen
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, wraps to 0 after
// the terminal count, and is forced to 0 by the clear input.
//
// Parameters:
//   TICK_DIV  clk cycles per tick (>= 2)
//   CNT_W     counter width, 2**CNT_W >= TICK_DIV
// Ports:
//   i_clk     system clock, rising edge
//   i_reset   asynchronous, active-high reset
//   i_clr     synchronous clear to 0 (has priority over i_en)
//   i_en      count enable
//   o_tc      high while enabled and the counter holds TICK_DIV-1
// -----------------------------------------------------------------------------
module hms_tick_gen #(
    parameter int TICK_DIV = 100_000_000,
    parameter int CNT_W    = 27
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_term;

    assign w_at_term = (r_cnt == TERM);
    assign o_tc      = i_en && w_at_term;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_at_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hms_timekeeper.sv
// -----------------------------------------------------------------------------
// hms_timekeeper
// Time-of-day register stage. Holds hour/min/sec, advances once per prescaled
// second while running, performs the 23:59:59 -> 00:00:00 rollover and accepts
// range-checked time loads over a valid/ready handshake.
//
// Optional feature macro: HMS_ALARM_EN (adds alarm_set/alarm_h/alarm_m inputs
// and the alarm output pulse).
//
// Parameters:
//   TICK_DIV  clk cycles per one-second tick (>= 2)
//   CNT_W     prescaler width, 2**CNT_W >= TICK_DIV
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   run        1 = advance on ticks, 0 = frozen
//   set_valid  load request; set_h/set_m/set_s stable while high
//   set_h/m/s  requested time
//   set_ready  high in IDLE/RUN; load accepted on set_valid && set_ready
//   set_err    one-cycle pulse: accepted load had an out-of-range field
//   hour/min/sec  current time
//   tick       one-cycle pulse aligned with the advanced time
//   day_wrap   one-cycle pulse with the tick that wraps to 00:00:00
//   alarm_set/alarm_h/alarm_m, alarm   (HMS_ALARM_EN only)
// -----------------------------------------------------------------------------
module hms_timekeeper
    import hms_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int CNT_W    = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              set_valid,
    input  logic [TIME_W-1:0] set_h,
    input  logic [TIME_W-1:0] set_m,
    input  logic [TIME_W-1:0] set_s,
    output logic              set_ready,
    output logic              set_err,
    output logic [TIME_W-1:0] hour,
    output logic [TIME_W-1:0] min,
    output logic [TIME_W-1:0] sec,
    output logic              tick,
    output logic              day_wrap
`ifdef HMS_ALARM_EN
    ,
    input  logic              alarm_set,
    input  logic [TIME_W-1:0] alarm_h,
    input  logic [TIME_W-1:0] alarm_m,
    output logic              alarm
`endif
);

    function automatic hms_t next_time(input hms_t t);
        hms_t n;
        if (t.sec < SEC_MAX) begin
            n.hour = t.hour;
            n.min  = t.min;
            n.sec  = t.sec + 6'd1;
        end else if (t.min < MIN_MAX) begin
            n.hour = t.hour;
            n.min  = t.min + 6'd1;
            n.sec  = '0;
        end else if (t.hour < HOUR_MAX) begin
            n.hour = t.hour + 6'd1;
            n.min  = '0;
            n.sec  = '0;
        end else begin
            n.hour = '0;
            n.min  = '0;
            n.sec  = '0;
        end
        return n;
    endfunction

    function automatic logic in_range(input hms_t t);
        return (t.hour <= HOUR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
    endfunction

    function automatic logic is_last(input hms_t t);
        return (t.hour == HOUR_MAX) && (t.min == MIN_MAX) && (t.sec == SEC_MAX);
    endfunction

    state_t r_state;
    hms_t   r_time;
    logic   r_set_ready;
    logic   r_set_err;
    logic   r_tick;
    logic   r_day_wrap;

    hms_t   w_set;
    hms_t   w_next;
    logic   w_accept;
    logic   w_running;
    logic   w_tc;
    logic   w_adv;

    assign w_set     = '{hour: set_h, min: set_m, sec: set_s};
    assign w_next    = next_time(r_time);
    assign w_accept  = set_valid && r_set_ready;
    assign w_running = (r_state == RUN);
    // A load on the terminal-count cycle wins; the tick is dropped.
    assign w_adv     = w_running && w_tc && !w_accept;

    // Cleared outside RUN, on a load, and when run drops so any partial
    // second is discarded.
    hms_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (!w_running || w_accept || !run),
        .i_en    (w_running),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_time      <= '0;
            r_set_ready <= 1'b1;
            r_set_err   <= 1'b0;
            r_tick      <= 1'b0;
            r_day_wrap  <= 1'b0;
        end else begin
            r_tick     <= w_adv;
            r_day_wrap <= w_adv && is_last(r_time);
            r_set_err  <= w_accept && !in_range(w_set);

            if (w_accept) begin
                if (in_range(w_set)) begin
                    r_time <= w_set;
                end
                r_state     <= LOAD;
                r_set_ready <= 1'b0;
            end else begin
                // A tick on the cycle run falls is still taken.
                if (w_adv) begin
                    r_time <= w_next;
                end
                case (r_state)
                    IDLE: begin
                        if (run) begin
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!run) begin
                            r_state <= IDLE;
                        end
                    end
                    LOAD: begin
                        r_state     <= run ? RUN : IDLE;
                        r_set_ready <= 1'b1;
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_set_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign hour      = r_time.hour;
    assign min       = r_time.min;
    assign sec       = r_time.sec;
    assign set_ready = r_set_ready;
    assign set_err   = r_set_err;
    assign tick      = r_tick;
    assign day_wrap  = r_day_wrap;

`ifdef HMS_ALARM_EN
    logic [TIME_W-1:0] r_al_h;
    logic [TIME_W-1:0] r_al_m;
    logic              r_alarm;
    hms_t              w_al_time;

    assign w_al_time = '{hour: r_al_h, min: r_al_m, sec: '0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_al_h  <= '0;
            r_al_m  <= '0;
            r_alarm <= 1'b0;
        end else begin
            // Only time advances can match; loads never raise the alarm.
            r_alarm <= w_adv && (w_next == w_al_time);
            if (alarm_set && (alarm_h <= HOUR_MAX) && (alarm_m <= MIN_MAX)) begin
                r_al_h <= alarm_h;
                r_al_m <= alarm_m;
            end
        end
    end

    assign alarm = r_alarm;
`endif

endmodule

// File: doc/hms_timekeeper.md
Name: hms_timekeeper

Overview:
- Sequential time-of-day register stage for the clock/timer datapath.
- Holds the current hour/minute/second and advances it once per second from a parameterised prescaler of the system clock.
- Performs the full 23:59:59 -> 00:00:00 rollover itself.
- Accepts a validated time-set load through a valid/ready handshake.
- Feeds the display/BCD stage downstream and provides the h/m/s operands for any incrementer stage.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per one-second tick (>= 2).
- CNT_W, 27, prescaler counter width; must satisfy 2**CNT_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = time advances on ticks, 0 = frozen (prescaler held at 0).
- set_valid  in  1  load request; set_h/set_m/set_s are stable while high.
- set_h  in  6  requested hour, 0..23.
- set_m  in  6  requested minute, 0..59.
- set_s  in  6  requested second, 0..59.
- set_ready  out  1  high in IDLE/RUN; a load is accepted when set_valid && set_ready.
- set_err  out  1  one-cycle pulse: an accepted load had an out-of-range field.
- hour  out  6  current hour.
- min  out  6  current minute.
- sec  out  6  current second.
- tick  out  1  one-cycle pulse on the cycle the time register advances.
- day_wrap  out  1  one-cycle pulse coincident with tick when 23:59:59 -> 00:00:00.

Behaviour:
- Reset (async assert, sync release):
  - hour=min=sec=0; prescaler=0.
  - tick=day_wrap=set_err=0.
  - State=IDLE; set_ready=1.
- States:
  - IDLE: run=0. Prescaler held at 0, time frozen. Goes to RUN when run=1.
  - RUN: prescaler counts 0..TICK_DIV-1. On the terminal count:
    - prescaler -> 0;
    - time register <= next_time;
    - tick=1 on the following cycle (registered pulse, aligned with the updated h/m/s).
    - Goes to IDLE when run=0. The prescaler resets to 0, so a partial second is discarded.
  - LOAD: entered from IDLE or RUN on an accepted handshake. Lasts exactly one cycle:
    - fields valid: hour/min/sec <= set_h/set_m/set_s;
    - any field out of range: time unchanged, set_err=1.
    - Prescaler cleared to 0; set_ready=0.
    - Next state is RUN if run=1, else IDLE.
- next_time (6-bit unsigned compares, no latches, every path assigns all three fields):
  - sec<59: sec+1.
  - else min<59: sec=0, min+1.
  - else hour<23: sec=0, min=0, hour+1.
  - else: all 0, day_wrap=1.
- Out-of-range register contents cannot occur, because loads are range-checked.
- First tick after entering RUN occurs TICK_DIV cycles after the run=1 sample.
- Simultaneous events:
  - Handshake on the prescaler terminal-count cycle: the load wins and no tick is issued.
  - run falling on the terminal-count cycle: the tick is still taken.
- Reset mid-LOAD: the load is abandoned and outputs take their reset values.

Optional Feature:
- Macro HMS_ALARM_EN.
- When defined, the block adds:
  - inputs alarm_set (1), alarm_h (6), alarm_m (6);
  - output alarm (1).
- alarm_set=1 captures alarm_h/alarm_m; out-of-range values are ignored. Alarm registers reset to 0:00.
- alarm is a one-cycle pulse, coincident with tick, when the new time equals alarm_h:alarm_m:00. It never fires on a LOAD.
- When undefined: the ports are absent and there is no alarm logic.

Decomposition:
- Shared package (hms_pkg) contents:
  - constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59, TIME_W=6;
  - state enum {IDLE, RUN, LOAD};
  - struct hms_t {hour, min, sec}.
- One sub-module, hms_tick_gen: prescaler with clear and enable inputs and a terminal-count output.
- next_time and the range check stay inline, as combinational functions.

Test Plan (TICK_DIV=4):
- Reset asserted mid-count -> outputs 0:00:00 immediately; set_ready=1; tick=0.
- run=1 from 0:00:00 for 16 cycles -> tick every 4 cycles; sec reads 1,2,3,4.
- Load 23:59:58 then run -> ticks give 23:59:59, then 00:00:00 with day_wrap=1 on that tick only.
- Load 12:59:59 and tick -> 13:00:00 with day_wrap=0.
- Load with set_m=60 -> set_err pulse, time unchanged. Load on the terminal-count cycle -> loaded value shown, no tick; next tick 4 cycles later.
- HMS_ALARM_EN: alarm 00:01, start 00:00:58 -> alarm pulses with the tick to 00:01:00, and on no other cycle.
